// File: rtl/hcounter_source.sv
// Test-traffic source: drives one 4-phase req/ack channel with a bounded run of
// {address, incrementing data, redundancy} messages, debouncing the incoming ack.
module hcounter_source #(
   parameter int ASZ       = 8,
   parameter int DSZ       = 8,
   parameter int RSZ       = 4,
   parameter int DST_ADDR  = 0,
   parameter int START_VAL = 0,
   parameter int NUM_MSGS  = 16,
   parameter int ACK_CKS   = 2,
   parameter int GAP_CKS   = 0
) (
   input  logic                     gch_clk,
   input  logic                     gch_reset,
   output logic                     gch_ready,
   output logic                     gch_done,
   input  logic                     snd0_rdy,
   output logic                     snd0_req,
   input  logic                     snd0_ack,
   output logic [ASZ+DSZ+RSZ-1:0]   snd0_dat
);
   localparam int CW = $clog2(ACK_CKS + 1);
   localparam int GW = (GAP_CKS > 0) ? $clog2(GAP_CKS + 1) : 1;
   localparam int SW = ((ASZ > DSZ) ? ASZ : DSZ) + 1;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ, S_WAIT_LO} state_t;

   state_t                   state, state_n;
   logic                     rg_rdy;
   logic                     req_n, done_n;
   logic [ASZ+DSZ+RSZ-1:0]   dat_n;
   logic [DSZ-1:0]           data, data_n;
   logic [31:0]              msg_cnt, cnt_n;
   logic [GW-1:0]            gap, gap_n;
   logic [CW-1:0]            cnt_hi, cnt_lo;
   logic                     ack_hi, ack_lo;
   logic [ASZ-1:0]           addr;
   logic [SW-1:0]            sum;
   logic [RSZ-1:0]           red;

   assign addr      = ASZ'(DST_ADDR);
   assign sum       = SW'(addr) + SW'(data);
   assign red       = RSZ'(sum);
   assign ack_hi    = (cnt_hi == CW'(ACK_CKS));
   assign ack_lo    = (cnt_lo == CW'(ACK_CKS));
   assign gch_ready = rg_rdy && snd0_rdy;

   // Saturating run-length counters: a level only counts once it has held ACK_CKS cycles.
   always_ff @(posedge gch_clk) begin
      if (gch_reset) begin
         cnt_hi <= '0;
         cnt_lo <= '0;
      end else begin
         if (!snd0_ack)                   cnt_hi <= '0;
         else if (cnt_hi != CW'(ACK_CKS)) cnt_hi <= cnt_hi + 1'b1;
         if (snd0_ack)                    cnt_lo <= '0;
         else if (cnt_lo != CW'(ACK_CKS)) cnt_lo <= cnt_lo + 1'b1;
      end
   end

   always_ff @(posedge gch_clk) begin
      if (gch_reset) begin
         state    <= S_INIT;
         rg_rdy   <= 1'b0;
         snd0_req <= 1'b0;
         snd0_dat <= '0;
         gch_done <= 1'b0;
         data     <= DSZ'(START_VAL);
         msg_cnt  <= '0;
         gap      <= '0;
      end else begin
         state    <= state_n;
         rg_rdy   <= 1'b1;
         snd0_req <= req_n;
         snd0_dat <= dat_n;
         gch_done <= done_n;
         data     <= data_n;
         msg_cnt  <= cnt_n;
         gap      <= gap_n;
      end
   end

   always_comb begin
      state_n = state;
      req_n   = snd0_req;
      dat_n   = snd0_dat;
      done_n  = gch_done;
      data_n  = data;
      cnt_n   = msg_cnt;
      gap_n   = gap;
      case (state)
         S_INIT: if (rg_rdy) state_n = S_IDLE;
         S_IDLE: begin
            if (gap != '0) begin
               gap_n = gap - 1'b1;
            end else if (!gch_done && snd0_rdy) begin
               // Data and req launch on the same edge so dat is stable while req=1.
               dat_n   = {addr, data, red};
               req_n   = 1'b1;
               state_n = S_REQ;
            end
         end
         S_REQ: begin
            if (ack_hi) begin
               req_n   = 1'b0;
               state_n = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (ack_lo) begin
               data_n  = data + 1'b1;
               cnt_n   = msg_cnt + 32'd1;
               gap_n   = GW'(GAP_CKS);
               state_n = S_IDLE;
               if (NUM_MSGS != 0 && cnt_n == 32'(NUM_MSGS)) done_n = 1'b1;
            end
         end
         default: state_n = S_INIT;
      endcase
   end
endmodule

// File: tb/tb_hcounter_source.sv
// Directed bench: instance a exercises reset, debounce, rdy gating and done;
// instance b free-runs 300 messages with a gap and an ideal receiver.
module tb_hcounter_source;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rdy_a, ack_a, ready_a, done_a, req_a;
   logic [19:0] dat_a;
   logic        rst_b, rdy_b, ready_b, done_b, req_b, ack_b;
   logic [19:0] dat_b;

   assign ack_b = req_b;

   hcounter_source #(.ASZ(8), .DSZ(8), .RSZ(4), .DST_ADDR(0), .START_VAL(8'hFE),
                     .NUM_MSGS(4), .ACK_CKS(3), .GAP_CKS(0)) u_a (
      .gch_clk(clk), .gch_reset(rst_a), .gch_ready(ready_a), .gch_done(done_a),
      .snd0_rdy(rdy_a), .snd0_req(req_a), .snd0_ack(ack_a), .snd0_dat(dat_a));

   hcounter_source #(.ASZ(8), .DSZ(8), .RSZ(4), .DST_ADDR(8'hA5), .START_VAL(8'hF0),
                     .NUM_MSGS(0), .ACK_CKS(2), .GAP_CKS(2)) u_b (
      .gch_clk(clk), .gch_reset(rst_b), .gch_ready(ready_b), .gch_done(done_b),
      .snd0_rdy(rdy_b), .snd0_req(req_b), .snd0_ack(ack_b), .snd0_dat(dat_b));

   int checks = 0;
   int errors = 0;
   logic [19:0] sb[$];
   logic [7:0]  exp_d;

   function automatic logic [19:0] mk(input logic [7:0] a, input logic [7:0] d);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, d};
      return {a, d, s[3:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for req on instance a and checks latency and payload against the scoreboard.
   task automatic wait_req(input string tag, input int lat);
      int n;
      logic [19:0] e;
      n = 0;
      while (!req_a && n < 40) begin tick(); n++; end
      chk({tag, "_req"}, {31'd0, req_a}, 32'd1);
      chk({tag, "_lat"}, n, lat);
      e = sb.pop_front();
      chk({tag, "_dat"}, {12'd0, dat_a}, {12'd0, e});
   endtask

   // Raise ack until req drops (ACK_CKS sampled highs + 1 edge), then release ack.
   task automatic handshake(input string tag);
      int n;
      ack_a = 1'b1;
      n = 0;
      while (req_a && n < 40) begin tick(); n++; end
      chk({tag, "_drop"}, n, 4);
      ack_a = 1'b0;
   endtask

   initial begin
      int p, n;
      rst_a = 1'b1; rdy_a = 1'b1; ack_a = 1'b0;
      rst_b = 1'b1; rdy_b = 1'b1;

      // Reset state
      repeat (5) tick();
      chk("rst_req", {31'd0, req_a}, 0);
      chk("rst_done", {31'd0, done_a}, 0);
      chk("rst_ready", {31'd0, ready_a}, 0);
      chk("rst_dat", {12'd0, dat_a}, 0);
      rst_a = 1'b0;
      tick();
      chk("ready_up", {31'd0, ready_a}, 1);
      chk("no_early_req", {31'd0, req_a}, 0);
      exp_d = 8'hFE;
      sb.push_back(mk(8'h00, exp_d));
      wait_req("m0", 2);

      // Short ack glitch must be ignored
      ack_a = 1'b1; tick(); tick();
      ack_a = 1'b0; repeat (3) tick();
      chk("glitch_req", {31'd0, req_a}, 1);
      chk("glitch_dat", {12'd0, dat_a}, {12'd0, mk(8'h00, 8'hFE)});
      handshake("m0");
      exp_d = exp_d + 8'd1;
      sb.push_back(mk(8'h00, exp_d));
      wait_req("m1", 5);

      // rdy drop mid-handshake: completes, next req held off
      rdy_a = 1'b0;
      handshake("m1");
      repeat (12) tick();
      chk("hold_req", {31'd0, req_a}, 0);
      chk("hold_ready", {31'd0, ready_a}, 0);
      rdy_a = 1'b1;
      exp_d = exp_d + 8'd1;
      sb.push_back(mk(8'h00, exp_d));
      wait_req("m2", 1);
      handshake("m2");
      exp_d = exp_d + 8'd1;
      sb.push_back(mk(8'h00, exp_d));
      wait_req("m3", 5);
      handshake("m3");
      repeat (3) tick();
      chk("done_early", {31'd0, done_a}, 0);
      tick();
      chk("done_set", {31'd0, done_a}, 1);
      repeat (20) tick();
      chk("no_5th_req", {31'd0, req_a}, 0);
      chk("done_hold", {31'd0, done_a}, 1);

      // Reset restarts from START_VAL; reset during REQ drops req at once
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      chk("rst2_done", {31'd0, done_a}, 0);
      exp_d = 8'hFE;
      sb.push_back(mk(8'h00, exp_d));
      wait_req("r0", 3);
      handshake("r0");
      sb.push_back(mk(8'h00, 8'hFF));
      wait_req("r1", 5);
      rst_a = 1'b1; tick();
      chk("abort_req", {31'd0, req_a}, 0);
      chk("abort_dat", {12'd0, dat_a}, 0);
      rst_a = 1'b0;
      for (int m = 0; m < 4; m++) begin
         sb.push_back(mk(8'h00, exp_d));
         wait_req("q", (m == 0) ? 3 : 5);
         handshake("q");
         exp_d = exp_d + 8'd1;
      end
      repeat (4) tick();
      chk("done_again", {31'd0, done_a}, 1);

      // Free-running instance with gap: period, payload and done every message
      rst_b = 1'b0;
      exp_d = 8'hF0;
      p = 0;
      for (int m = 0; m < 300; m++) begin
         sb.push_back(mk(8'hA5, exp_d));
         n = 0;
         while (!req_b && n < 50) begin tick(); n++; p++; end
         chk("b_req", {31'd0, req_b}, 1);
         chk("b_period", p, (m == 0) ? 3 : 9);
         chk("b_dat", {12'd0, dat_b}, {12'd0, sb.pop_front()});
         chk("b_done", {31'd0, done_b}, 0);
         p = 0;
         n = 0;
         while (req_b && n < 50) begin tick(); n++; p++; end
         exp_d = exp_d + 8'd1;
      end
      chk("b_ready", {31'd0, ready_b}, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
